// File: rtl/slant_lane_tx_pkg.sv
// Shared Slant camera-link constants: framing patterns, symbol widths, FSM
// state codes and the header chunk selector used by both lane ends.
package slant_link_pkg;

  localparam int SYM_W    = 6;
  localparam int SAMPLE_W = 5;

  localparam logic [23:0]      FRAME0   = 24'haa8d55;
  localparam logic [23:0]      FRAME1   = 24'haab155;
  localparam logic [7:0]       HSYNC    = 8'h55;
  localparam logic [SYM_W-1:0] IDLE_SYM = 6'h00;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_HDR    = 3'd1;
  localparam tx_state_t ST_HSYNC  = 3'd2;
  localparam tx_state_t ST_DATA_Y = 3'd3;
  localparam tx_state_t ST_DATA_C = 3'd4;
  localparam tx_state_t ST_GAP    = 3'd5;

  // Headers go out MSB chunk first, so index 0 is bits [23:18].
  function automatic logic [SYM_W-1:0] hdr_sym(input logic [23:0] hdr,
                                               input logic [1:0]  idx);
    case (idx)
      2'd0:    hdr_sym = hdr[23:18];
      2'd1:    hdr_sym = hdr[17:12];
      2'd2:    hdr_sym = hdr[11:6];
      default: hdr_sym = hdr[5:0];
    endcase
  endfunction

endpackage

// File: rtl/slant_lane_tx_if.sv
// Pixel stream feeding one Slant lane transmitter: valid/ready handshake with
// a start-of-frame flag and one Y/C sample pair per beat.
interface slant_lane_tx_if;
  import slant_link_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic                s_sof;
  logic [SAMPLE_W-1:0] s_y;
  logic [SAMPLE_W-1:0] s_c;

  modport master (output s_valid, s_sof, s_y, s_c, input s_ready);
  modport slave  (input s_valid, s_sof, s_y, s_c, output s_ready);

endinterface

// File: rtl/slant_lane_tx.sv
// Transmit side of one Slant lane: frames a Y/C pixel stream into headers,
// HSYNC markers, Y,C symbol pairs and idle gaps, one registered symbol per clk.
module slant_lane_tx
  import slant_link_pkg::*;
#(
  parameter int LINE_PIX    = 160,
  parameter int FRAME_LINES = 240,
  parameter int LINE_GAP    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  slant_lane_tx_if.slave   pix,
  output logic [SYM_W-1:0] tx_data,
  output logic             tx_frame_odd,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int PIX_W  = (LINE_PIX    > 1) ? $clog2(LINE_PIX)    : 1;
  localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int GAP_W  = (LINE_GAP    > 1) ? $clog2(LINE_GAP)    : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIX - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LINE_GAP - 1);

  tx_state_t           state;
  logic [1:0]          sym_cnt;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [SAMPLE_W-1:0] c_hold;

  // IDLE drains stray mid-frame pixels so the next SOF lands at the head.
  always_comb begin
    pix.s_ready = 1'b0;
    if (!rst) begin
      if (state == ST_IDLE)
        pix.s_ready = pix.s_valid & ~pix.s_sof;
      else if (state == ST_DATA_Y)
        pix.s_ready = 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      sym_cnt      <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      gap_cnt      <= '0;
      c_hold       <= '0;
      tx_data      <= IDLE_SYM;
      tx_frame_odd <= 1'b1;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      tx_data    <= IDLE_SYM;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && pix.s_valid && pix.s_sof) begin
            tx_frame_odd <= ~tx_frame_odd;
            sym_cnt      <= '0;
            state        <= ST_HDR;
          end
        end
        ST_HDR: begin
          tx_data <= hdr_sym(tx_frame_odd ? FRAME1 : FRAME0, sym_cnt);
          sym_cnt <= sym_cnt + 2'd1;
          if (sym_cnt == 2'd3) begin
            line_cnt <= '0;
            state    <= ST_HSYNC;
          end
        end
        ST_HSYNC: begin
          tx_data <= HSYNC[SYM_W-1:0];
          pix_cnt <= '0;
          state   <= ST_DATA_Y;
        end
        // A missing pixel still occupies its slot so line timing never slips.
        ST_DATA_Y: begin
          if (pix.s_valid) begin
            tx_data <= {1'b0, pix.s_y};
            c_hold  <= pix.s_c;
          end else begin
            c_hold   <= '0;
            underrun <= 1'b1;
          end
          state <= ST_DATA_C;
        end
        ST_DATA_C: begin
          tx_data <= {1'b0, c_hold};
          if (pix_cnt == PIX_LAST) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            state   <= ST_DATA_Y;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (line_cnt == LINE_LAST) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              line_cnt <= line_cnt + LINE_W'(1);
              state    <= ST_HSYNC;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slant_lane_tx.sv
// Self-checking bench for slant_lane_tx: pixel source queue plus an expected
// symbol scoreboard popped once per clock, with an IDLE handshake vector table.
module tb_slant_lane_tx;
  import slant_link_pkg::*;

  localparam int LINE_PIX    = 4;
  localparam int FRAME_LINES = 2;
  localparam int LINE_GAP    = 2;
  localparam int SLOTS       = LINE_PIX * FRAME_LINES;

  typedef struct {
    logic       hole;
    logic       sof;
    logic [4:0] y;
    logic [4:0] c;
  } src_t;

  typedef struct {
    logic [5:0] sym;
    logic       fd;
    logic       ur;
    logic       odd;
    logic       bsy;
  } exp_t;

  typedef struct {
    logic valid;
    logic sof;
    logic en;
    logic exp_ready;
  } idle_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] tx_data;
  logic       tx_frame_odd;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  slant_lane_tx_if pix ();

  slant_lane_tx #(
    .LINE_PIX   (LINE_PIX),
    .FRAME_LINES(FRAME_LINES),
    .LINE_GAP   (LINE_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pix         (pix),
    .tx_data     (tx_data),
    .tx_frame_odd(tx_frame_odd),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  src_t       src_q[$];
  exp_t       exp_q[$];
  idle_vec_t  idle_tbl[6];
  int         checks   = 0;
  int         failures = 0;
  int         sym_idx  = 0;
  logic [5:0] hdr_even[4] = '{6'h2A, 6'h28, 6'h35, 6'h15};
  logic [5:0] hdr_odd[4]  = '{6'h2A, 6'h2B, 6'h05, 6'h15};

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [5:0] sym, input bit fd, input bit ur,
                          input bit odd, input bit bsy);
    exp_t e;
    e.sym = sym; e.fd = fd; e.ur = ur; e.odd = odd; e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input bit odd);
    for (int i = 0; i < n; i++) push_exp(6'h00, 1'b0, 1'b0, odd, 1'b0);
  endtask

  task automatic load_src(input int base, input int miss);
    src_t s;
    for (int k = 0; k < SLOTS; k++) begin
      s.hole = (k == miss);
      s.sof  = (k == 0);
      s.y    = s.hole ? 5'h1f : 5'(base + k);
      s.c    = s.hole ? 5'h1f : 5'(16 + base + k);
      src_q.push_back(s);
    end
  endtask

  // Expected stream starts with the IDLE symbol emitted on the start edge.
  task automatic load_exp(input bit odd, input int base, input int miss);
    bit last;
    push_exp(6'h00, 1'b0, 1'b0, odd, 1'b1);
    for (int k = 0; k < 4; k++)
      push_exp(odd ? hdr_odd[k] : hdr_even[k], 1'b0, 1'b0, odd, 1'b1);
    for (int ln = 0; ln < FRAME_LINES; ln++) begin
      push_exp(6'h15, 1'b0, 1'b0, odd, 1'b1);
      for (int p = 0; p < LINE_PIX; p++) begin
        int s;
        s = ln * LINE_PIX + p;
        if (s == miss) begin
          push_exp(6'h00, 1'b0, 1'b1, odd, 1'b1);
          push_exp(6'h00, 1'b0, 1'b0, odd, 1'b1);
        end else begin
          push_exp({1'b0, 5'(base + s)}, 1'b0, 1'b0, odd, 1'b1);
          push_exp({1'b0, 5'(16 + base + s)}, 1'b0, 1'b0, odd, 1'b1);
        end
      end
      for (int g = 0; g < LINE_GAP; g++) begin
        last = (ln == FRAME_LINES - 1) && (g == LINE_GAP - 1);
        push_exp(6'h00, last, 1'b0, odd, !last);
      end
    end
  endtask

  // One clock: offer the head pixel, retire it on handshake, score outputs.
  task automatic apply_stimulus();
    bit   took;
    exp_t e;
    if (src_q.size() > 0) begin
      pix.s_valid = !src_q[0].hole;
      pix.s_sof   = src_q[0].sof;
      pix.s_y     = src_q[0].y;
      pix.s_c     = src_q[0].c;
    end else begin
      pix.s_valid = 1'b0;
      pix.s_sof   = 1'b0;
      pix.s_y     = 5'h00;
      pix.s_c     = 5'h00;
    end
    #1;
    took = pix.s_ready && (src_q.size() > 0);
    @(posedge clk);
    #1;
    if (took) src_q.delete(0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output($sformatf("tx_data[%0d]", sym_idx), 32'(tx_data), 32'(e.sym));
      check_output($sformatf("frame_done[%0d]", sym_idx), 32'(frame_done), 32'(e.fd));
      check_output($sformatf("underrun[%0d]", sym_idx), 32'(underrun), 32'(e.ur));
      check_output($sformatf("frame_odd[%0d]", sym_idx), 32'(tx_frame_odd), 32'(e.odd));
      check_output($sformatf("busy[%0d]", sym_idx), 32'(busy), 32'(e.bsy));
      sym_idx++;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    src_t fl;
    idle_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    idle_tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    idle_tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
    idle_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    idle_tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    idle_tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    pix.s_valid = 1'b1;
    pix.s_sof   = 1'b0;
    pix.s_y     = 5'h03;
    pix.s_c     = 5'h04;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_tx_data", 32'(tx_data), 32'h00);
    check_output("rst_s_ready", 32'(pix.s_ready), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_underrun", 32'(underrun), 32'd0);
    check_output("rst_frame_odd", 32'(tx_frame_odd), 32'd1);

    rst = 1'b0;
    pix.s_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      pix.s_valid = idle_tbl[i].valid;
      pix.s_sof   = idle_tbl[i].sof;
      en          = idle_tbl[i].en;
      #1;
      check_output($sformatf("idle_ready[%0d]", i), 32'(pix.s_ready),
                   32'(idle_tbl[i].exp_ready));
    end
    pix.s_valid = 1'b0;
    pix.s_sof   = 1'b0;
    en          = 1'b1;

    $display("[TB] basic frames even/odd/even");
    load_src(0, -1);  load_exp(1'b0, 0, -1);
    load_src(8, -1);  load_exp(1'b1, 8, -1);
    load_src(16, -1); load_exp(1'b0, 16, -1);
    drain(400);
    check_output("basic_src_left", 32'(src_q.size()), 32'd0);

    $display("[TB] flush of non-SOF pixels in IDLE");
    for (int k = 0; k < 3; k++) begin
      fl.hole = 1'b0; fl.sof = 1'b0; fl.y = 5'(20 + k); fl.c = 5'(25 + k);
      src_q.push_back(fl);
    end
    load_src(2, -1);
    push_idle(3, 1'b0);
    load_exp(1'b1, 2, -1);
    drain(200);
    check_output("flush_src_left", 32'(src_q.size()), 32'd0);

    $display("[TB] underrun at pixel 2");
    load_src(4, 2);
    load_exp(1'b0, 4, 2);
    drain(200);
    check_output("underrun_src_left", 32'(src_q.size()), 32'd0);

    $display("[TB] en dropped during header");
    load_src(12, -1);
    load_exp(1'b1, 12, -1);
    repeat (2) apply_stimulus();
    en = 1'b0;
    drain(200);
    check_output("enlow_src_left", 32'(src_q.size()), 32'd0);
    load_src(20, -1);
    push_idle(6, 1'b1);
    drain(50);
    check_output("enlow_sof_held", 32'(src_q.size()), 32'(SLOTS));

    $display("[TB] reset at line 1 pixel 1");
    en = 1'b1;
    load_exp(1'b0, 20, -1);
    repeat (19) apply_stimulus();
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    apply_stimulus();
    check_output("midrst_tx_data", 32'(tx_data), 32'h00);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_s_ready", 32'(pix.s_ready), 32'd0);
    check_output("midrst_frame_odd", 32'(tx_frame_odd), 32'd1);
    rst = 1'b0;
    load_src(24, -1);
    load_exp(1'b0, 24, -1);
    drain(200);
    check_output("postrst_src_left", 32'(src_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
